// File: rtl/sad_min_skid_pipe_reg.sv
// SAD->MIN stage boundary register with a 2-entry skid buffer.
// Ports: clk, rst_n (async low), flush; in_valid/in_ready/in_trigger/in_index/in_value
// upstream; out_valid/out_ready/out_trigger/out_index/out_value downstream; occupancy.
module sad_min_skid_pipe_reg #(
    parameter int NUM_CORES = 8,
    parameter int IDX_W     = 16,
    parameter int VAL_W     = 14
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flush,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic                       in_trigger,
    input  logic [NUM_CORES*IDX_W-1:0] in_index,
    input  logic [NUM_CORES*VAL_W-1:0] in_value,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic                       out_trigger,
    output logic [NUM_CORES*IDX_W-1:0] out_index,
    output logic [NUM_CORES*VAL_W-1:0] out_value,
    output logic [1:0]                 occupancy
);

    localparam int PW = 1 + NUM_CORES * (IDX_W + VAL_W);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic            in_ready_q;
    logic [PW-1:0]   main_q, skid_q, in_word;
    logic            in_acc;
    logic            ld_main_in, ld_main_skid, ld_skid;

    assign in_word = {in_trigger, in_index, in_value};
    assign in_acc  = in_valid & in_ready_q;

    always_comb begin
        state_d      = state_q;
        ld_main_in   = 1'b0;
        ld_main_skid = 1'b0;
        ld_skid      = 1'b0;
        if (flush) begin
            state_d = EMPTY;
        end else begin
            unique case (state_q)
                EMPTY: begin
                    if (in_acc) begin
                        ld_main_in = 1'b1;
                        state_d    = ONE;
                    end
                end
                ONE: begin
                    if (in_acc && out_ready) begin
                        ld_main_in = 1'b1;
                    end else if (in_acc) begin
                        // Downstream stalled: park the new beat behind MAIN.
                        ld_skid = 1'b1;
                        state_d = FULL;
                    end else if (out_ready) begin
                        state_d = EMPTY;
                    end
                end
                FULL: begin
                    if (out_ready) begin
                        ld_main_skid = 1'b1;
                        state_d      = ONE;
                    end
                end
                default: state_d = EMPTY;
            endcase
        end
    end

    // in_ready is computed from the next state so it leaves a flop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= EMPTY;
            in_ready_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            in_ready_q <= (state_d != FULL);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_q <= '0;
            skid_q <= '0;
        end else begin
            if (ld_main_in) begin
                main_q <= in_word;
            end else if (ld_main_skid) begin
                main_q <= skid_q;
            end
            if (ld_skid) begin
                skid_q <= in_word;
            end
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = (state_q != EMPTY);
    assign occupancy = (state_q == FULL) ? 2'd2 :
                       (state_q == ONE)  ? 2'd1 : 2'd0;
    assign {out_trigger, out_index, out_value} = main_q;

endmodule

// File: tb/tb_sad_min_skid_pipe_reg.sv
// Randomised and directed bench for sad_min_skid_pipe_reg against a queue model.
// Second instance covers a narrower parameter set.
module tb_sad_min_skid_pipe_reg;

    localparam int NC = 8;
    localparam int IW = 16;
    localparam int VW = 14;
    localparam int PW = 1 + NC * (IW + VW);

    localparam int NC2 = 4;
    localparam int IW2 = 10;
    localparam int VW2 = 12;
    localparam int PW2 = 1 + NC2 * (IW2 + VW2);

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst_n;
    logic             flush;
    logic             in_valid, in_ready, in_trigger;
    logic [NC*IW-1:0] in_index;
    logic [NC*VW-1:0] in_value;
    logic             out_valid, out_ready, out_trigger;
    logic [NC*IW-1:0] out_index;
    logic [NC*VW-1:0] out_value;
    logic [1:0]       occupancy;

    logic               flush2;
    logic               in_valid2, in_ready2, in_trigger2;
    logic [NC2*IW2-1:0] in_index2;
    logic [NC2*VW2-1:0] in_value2;
    logic               out_valid2, out_ready2, out_trigger2;
    logic [NC2*IW2-1:0] out_index2;
    logic [NC2*VW2-1:0] out_value2;
    logic [1:0]         occupancy2;

    sad_min_skid_pipe_reg dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_trigger  (in_trigger),
        .in_index    (in_index),
        .in_value    (in_value),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_trigger (out_trigger),
        .out_index   (out_index),
        .out_value   (out_value),
        .occupancy   (occupancy)
    );

    sad_min_skid_pipe_reg #(
        .NUM_CORES (NC2),
        .IDX_W     (IW2),
        .VAL_W     (VW2)
    ) dut2 (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush       (flush2),
        .in_valid    (in_valid2),
        .in_ready    (in_ready2),
        .in_trigger  (in_trigger2),
        .in_index    (in_index2),
        .in_value    (in_value2),
        .out_valid   (out_valid2),
        .out_ready   (out_ready2),
        .out_trigger (out_trigger2),
        .out_index   (out_index2),
        .out_value   (out_value2),
        .occupancy   (occupancy2)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int n_acc = 0;
    logic [PW-1:0] q[$];

    task automatic chk(input string tag, input logic [255:0] got,
                       input logic [255:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_model();
        chk("occupancy", 256'(occupancy), 256'(q.size()));
        chk("in_ready", 256'(in_ready), 256'(q.size() < 2));
        chk("out_valid", 256'(out_valid), 256'(q.size() != 0));
        if (q.size() != 0)
            chk("payload", 256'({out_trigger, out_index, out_value}), 256'(q[0]));
    endtask

    // Advance the model by the handshake that the next rising edge will see,
    // then sample the DUT on the following falling edge.
    task automatic cycle();
        bit ia, oa;
        ia = in_valid && (q.size() < 2);
        oa = (q.size() != 0) && out_ready;
        if (flush) begin
            q.delete();
        end else begin
            if (oa) void'(q.pop_front());
            if (ia) begin
                q.push_back({in_trigger, in_index, in_value});
                n_acc++;
            end
        end
        @(negedge clk);
        check_model();
    endtask

    task automatic rand_beat();
        in_trigger = 1'($urandom);
        for (int k = 0; k < NC; k++) begin
            in_index[k*IW +: IW] = IW'($urandom);
            in_value[k*VW +: VW] = VW'($urandom);
        end
    endtask

    task automatic fill_two();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        rand_beat();
        cycle();
        rand_beat();
        cycle();
    endtask

    initial begin
        logic [PW2-1:0] exp2;
        int cyc;

        rst_n = 1'b1;
        flush = 1'b0;
        in_valid = 1'b0;
        in_trigger = 1'b0;
        in_index = '0;
        in_value = '0;
        out_ready = 1'b0;
        flush2 = 1'b0;
        in_valid2 = 1'b0;
        in_trigger2 = 1'b0;
        in_index2 = '0;
        in_value2 = '0;
        out_ready2 = 1'b0;
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_out_valid", 256'(out_valid), 256'(0));
        chk("rst_in_ready", 256'(in_ready), 256'(1));
        chk("rst_occ", 256'(occupancy), 256'(0));
        chk("rst_payload", 256'({out_trigger, out_index, out_value}), 256'(0));
        rst_n = 1'b1;
        @(negedge clk);
        check_model();

        // streaming, one beat per cycle
        out_ready = 1'b1;
        for (int b = 0; b < 12; b++) begin
            in_valid   = 1'b1;
            in_trigger = (b % 4 == 3);
            for (int k = 0; k < NC; k++) begin
                in_index[k*IW +: IW] = IW'(16'h100 + k);
                in_value[k*VW +: VW] = VW'(k + 1 + b);
            end
            cycle();
        end
        in_valid = 1'b0;
        repeat (2) cycle();

        // stall with A, B, then an ignored beat while FULL, then release
        fill_two();
        rand_beat();
        cycle();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (3) cycle();

        // flush in FULL with a beat offered
        fill_two();
        flush = 1'b1;
        rand_beat();
        cycle();
        flush = 1'b0;
        in_valid = 1'b0;
        cycle();
        in_valid  = 1'b1;
        out_ready = 1'b1;
        rand_beat();
        cycle();
        in_valid = 1'b0;
        repeat (2) cycle();

        // random valid/ready traffic
        n_acc = 0;
        cyc = 0;
        while (n_acc < 1000 && cyc < 20000) begin
            in_valid  = 1'($urandom);
            out_ready = 1'($urandom);
            rand_beat();
            cycle();
            cyc++;
        end
        chk("rand_beats_accepted", 256'(n_acc), 256'(1000));
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (3) cycle();

        // asynchronous reset while FULL and offered a beat
        fill_two();
        rand_beat();
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("amid_out_valid", 256'(out_valid), 256'(0));
        chk("amid_in_ready", 256'(in_ready), 256'(1));
        chk("amid_occ", 256'(occupancy), 256'(0));
        chk("amid_payload", 256'({out_trigger, out_index, out_value}), 256'(0));
        q.delete();
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check_model();
        in_valid  = 1'b1;
        out_ready = 1'b1;
        rand_beat();
        cycle();
        in_valid = 1'b0;
        repeat (2) cycle();

        // narrow parameter set, all-ones lane 3
        in_valid2   = 1'b1;
        out_ready2  = 1'b1;
        in_trigger2 = 1'b1;
        for (int k = 0; k < 3; k++) begin
            in_index2[k*IW2 +: IW2] = IW2'(k + 5);
            in_value2[k*VW2 +: VW2] = VW2'(k + 9);
        end
        in_index2[3*IW2 +: IW2] = 10'h3FF;
        in_value2[3*VW2 +: VW2] = 12'hFFF;
        exp2 = {in_trigger2, in_index2, in_value2};
        chk("p2_in_ready", 256'(in_ready2), 256'(1));
        @(negedge clk);
        in_valid2 = 1'b0;
        chk("p2_out_valid", 256'(out_valid2), 256'(1));
        chk("p2_occ", 256'(occupancy2), 256'(1));
        chk("p2_payload", 256'({out_trigger2, out_index2, out_value2}), 256'(exp2));
        chk("p2_lane3_idx", 256'(out_index2[3*IW2 +: IW2]), 256'(10'h3FF));
        chk("p2_lane3_val", 256'(out_value2[3*VW2 +: VW2]), 256'(12'hFFF));
        @(negedge clk);
        chk("p2_drained", 256'(out_valid2), 256'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
